apb_master_bridge: RTL and testbench

//  Upstream neighbour of apb_slave: turns single-beat commands (valid/ready) into APB transfers.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_wait_timer.sv | 39 +++
 rtl/apb_master_bridge.sv | 141 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge and its helpers.
// Widths default to the apb_slave neighbour so the two drop together without overrides.
package apb_pkg;

   localparam int DEFAULT_A_WIDTH = 8;
   localparam int DEFAULT_D_WIDTH = 8;
   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mst_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired_o flags the increment that reaches TIMEOUT.
// TIMEOUT of zero disables expiry and freezes the counter at zero.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Saturate at LIMIT so a slave that ignores the abort can never wrap the count.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != LIMIT)) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (TIMEOUT != 0) && inc_i && (count_d == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Turns single-beat valid/ready commands into APB SETUP/ACCESS transfers and returns
// a one-cycle registered response; a wait-state timer aborts transfers to a hung slave.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int A_WIDTH = DEFAULT_A_WIDTH,
   parameter int D_WIDTH = DEFAULT_D_WIDTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic               p_clk,
   input  logic               p_rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_write,
   input  logic [A_WIDTH-1:0] cmd_addr,
   input  logic [D_WIDTH-1:0] cmd_wdata,
   output logic               rsp_valid,
   output logic [D_WIDTH-1:0] rsp_rdata,
   output logic               rsp_err,
   output logic               rsp_timeout,
   output logic               p_sel,
   output logic               p_enable,
   output logic               p_write,
   output logic [A_WIDTH-1:0] p_addr,
   output logic [D_WIDTH-1:0] wr_data,
   input  logic [D_WIDTH-1:0] rd_data,
   input  logic               p_ready,
   input  logic               p_slverr
);

   apb_mst_state_e state_q, state_d;

   logic               write_q, write_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [D_WIDTH-1:0] wdata_q, wdata_d;

   logic               rsp_valid_q, rsp_valid_d;
   logic [D_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_timeout_q, rsp_timeout_d;

   logic timer_clear;
   logic timer_inc;
   logic timer_expired;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk_i     (p_clk),
      .rst_i     (p_rst),
      .clear_i   (timer_clear),
      .inc_i     (timer_inc),
      .expired_o (timer_expired)
   );

   // Response fields hold between transfers; only rsp_valid defaults low each cycle.
   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      timer_clear   = 1'b0;
      timer_inc     = 1'b0;
      cmd_ready     = 1'b0;
      p_sel         = 1'b0;
      p_enable      = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               write_d     = cmd_write;
               addr_d      = cmd_addr;
               wdata_d     = cmd_write ? cmd_wdata : '0;
               timer_clear = 1'b1;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            p_sel   = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            p_sel    = 1'b1;
            p_enable = 1'b1;
            if (p_ready) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = p_slverr;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = write_q ? '0 : rd_data;
               state_d       = IDLE;
            end else begin
               timer_inc = 1'b1;
               if (timer_expired) begin
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b1;
                  rsp_rdata_d   = '0;
                  state_d       = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         state_q       <= IDLE;
         write_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign p_write     = write_q;
   assign p_addr      = addr_q;
   assign wr_data     = wdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a behavioural APB slave with programmable wait states and
// errors, plus a transfer-level reference model for phase timing, bus values and responses.
module tb_apb_master_bridge;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 4;

   logic          p_clk = 1'b0;
   logic          p_rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          p_sel;
   logic          p_enable;
   logic          p_write;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data;
   logic          p_ready;
   logic          p_slverr;

   int checkCount = 0;
   int failCount  = 0;

   logic [DW-1:0] refMem [256];
   logic [DW-1:0] slvMem [256];
   int            slvWaits = 0;
   bit            slvErr   = 1'b0;
   int            accCnt   = 0;
   logic [9:0]    lastRsp  = '0;

   apb_master_bridge #(
      .A_WIDTH (AW),
      .D_WIDTH (DW),
      .TIMEOUT (TO)
   ) dut (
      .p_clk       (p_clk),
      .p_rst       (p_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .p_sel       (p_sel),
      .p_enable    (p_enable),
      .p_write     (p_write),
      .p_addr      (p_addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .p_ready     (p_ready),
      .p_slverr    (p_slverr)
   );

   always #5 p_clk = ~p_clk;

   // Slave drives on the falling edge; outside the completing ACCESS cycle it drives noise.
   always @(negedge p_clk) begin
      if (p_sel && p_enable) begin
         p_ready = (accCnt >= slvWaits);
         if (p_ready) begin
            p_slverr = slvErr;
            rd_data  = slvMem[p_addr];
            if (p_write && !slvErr) slvMem[p_addr] = wr_data;
         end else begin
            p_slverr = 1'($urandom);
            rd_data  = 8'($urandom);
         end
         accCnt++;
      end else begin
         accCnt   = 0;
         p_ready  = 1'($urandom);
         p_slverr = 1'($urandom);
         rd_data  = 8'($urandom);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One complete transfer, entered and left on a falling edge with the bridge idle.
   task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                                input int waits, input bit err);
      bit            abort;
      int            accCycles;
      logic [DW-1:0] expWd;
      logic [DW-1:0] expRd;
      abort     = (TO != 0) && (waits >= TO);
      accCycles = abort ? TO : waits + 1;
      expWd     = wr ? data : 8'h00;
      expRd     = (abort || wr) ? 8'h00 : refMem[addr];

      checkOutput("idleReady", 32'(cmd_ready), 32'd1);
      slvWaits  = waits;
      slvErr    = err;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      @(negedge p_clk);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
      checkOutput("setupPhase", 32'({p_sel, p_enable}), 32'b10);
      checkOutput("setupBus", 32'({p_write, p_addr, wr_data}), 32'({wr, addr, expWd}));
      checkOutput("setupNotReady", 32'(cmd_ready), 32'd0);
      for (int c = 0; c < accCycles; c++) begin
         @(negedge p_clk);
         checkOutput("accessPhase", 32'({p_sel, p_enable}), 32'b11);
         checkOutput("accessBus", 32'({p_write, p_addr, wr_data}), 32'({wr, addr, expWd}));
         checkOutput("earlyRsp", 32'(rsp_valid), 32'd0);
      end
      @(negedge p_clk);
      checkOutput("rspValid", 32'(rsp_valid), 32'd1);
      checkOutput("rspFields", 32'({rsp_err, rsp_timeout, rsp_rdata}),
                  32'({(abort || err), abort, expRd}));
      checkOutput("busIdle", 32'({p_sel, p_enable}), 32'b00);
      lastRsp = {(abort || err), abort, expRd};
      if (!abort && wr && !err) refMem[addr] = data;
   endtask

   // One idle cycle: the pulse must be gone while the response fields hold.
   task automatic idleGap();
      @(negedge p_clk);
      checkOutput("rspPulse", 32'(rsp_valid), 32'd0);
      checkOutput("rspHold", 32'({rsp_err, rsp_timeout, rsp_rdata}), 32'(lastRsp));
   endtask

   task automatic resetDuringAccess();
      slvWaits  = 3;
      slvErr    = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h55;
      cmd_wdata = 8'h99;
      @(negedge p_clk);
      cmd_valid = 1'b0;
      @(negedge p_clk);
      checkOutput("rstInAccess", 32'({p_sel, p_enable}), 32'b11);
      p_rst = 1'b1;
      @(negedge p_clk);
      checkOutput("rstBusIdle", 32'({p_sel, p_enable}), 32'b00);
      checkOutput("rstNoRsp", 32'(rsp_valid), 32'd0);
      p_rst = 1'b0;
      @(negedge p_clk);
      checkOutput("rstReady", 32'(cmd_ready), 32'd1);
      checkOutput("rstRspClear", 32'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 32'd0);
      lastRsp = '0;
   endtask

   task automatic backToBack(input logic [7:0] data);
      int setups    = 0;
      int lastSetup = -1;
      int rspCount  = 0;
      slvWaits  = 0;
      slvErr    = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h70;
      cmd_wdata = data;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge p_clk);
         checkOutput("enableOnlyInAccess", 32'(p_enable && !p_sel), 32'd0);
         if (p_sel && !p_enable) begin
            if (lastSetup >= 0) checkOutput("b2bSpacing", 32'(cyc - lastSetup), 32'd3);
            lastSetup = cyc;
            setups++;
            if (setups == 3) cmd_valid = 1'b0;
         end
         if (rsp_valid) rspCount++;
      end
      checkOutput("b2bSetups", 32'(setups), 32'd3);
      checkOutput("b2bResponses", 32'(rspCount), 32'd3);
      refMem[8'h70] = data;
      lastRsp = '0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      p_rst     = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      p_ready   = 1'b0;
      p_slverr  = 1'b0;
      rd_data   = '0;
      for (int i = 0; i < 256; i++) begin
         refMem[i] = 8'($urandom);
         slvMem[i] = refMem[i];
      end
      repeat (3) @(negedge p_clk);
      checkOutput("resetOutputs",
                  32'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, p_sel, p_enable, p_write}), 32'd0);
      checkOutput("resetBus", 32'({p_addr, wr_data}), 32'd0);
      p_rst = 1'b0;
      @(negedge p_clk);
      checkOutput("resetReady", 32'(cmd_ready), 32'd1);

      $display("[TB] directed transfers");
      applyStimulus(1'b1, 8'h45, 8'hA5, 0, 1'b0);
      idleGap();
      refMem[8'h65] = 8'h3C;
      slvMem[8'h65] = 8'h3C;
      applyStimulus(1'b0, 8'h65, 8'h00, 2, 1'b0);
      idleGap();
      applyStimulus(1'b0, 8'h94, 8'h00, 1, 1'b1);
      idleGap();
      applyStimulus(1'b0, 8'h20, 8'h00, 100, 1'b0);
      idleGap();
      applyStimulus(1'b0, 8'h45, 8'h00, TO - 1, 1'b0);
      applyStimulus(1'b1, 8'h46, 8'h77, TO, 1'b0);
      idleGap();

      $display("[TB] reset during access");
      resetDuringAccess();
      applyStimulus(1'b0, 8'h55, 8'h00, 0, 1'b0);
      idleGap();

      $display("[TB] back-to-back commands");
      backToBack(8'hC3);
      applyStimulus(1'b0, 8'h70, 8'h00, 0, 1'b0);
      idleGap();

      $display("[TB] randomized transfers");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'($urandom), 8'(8'h40 + $urandom_range(0, 7)), 8'($urandom),
                       int'($urandom_range(0, TO + 1)), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idleGap();
      end

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
